// File: rtl/cmp_pkg.sv
// Shared definitions for the compare/branch unit: funct3 encodings, the S1
// payload carried between pipeline stages, and the result-decode helpers.
package cmp_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef struct packed {
    logic       is_branch;
    logic [2:0] funct3;
    logic       eq;
    logic       lt;
  } s1_payload_t;

  // Signed ops share the unsigned comparator with both operand MSBs inverted.
  function automatic logic is_signed_op(input logic is_branch, input logic [2:0] funct3);
    if (is_branch) return (funct3 == F3_BLT) || (funct3 == F3_BGE);
    return funct3 == F3_SLT;
  endfunction

  // Returns {taken, slt_bit}; illegal encodings decode to zero.
  function automatic logic [1:0] resolve(input s1_payload_t p);
    logic taken;
    logic slt_bit;
    taken   = 1'b0;
    slt_bit = 1'b0;
    if (p.is_branch) begin
      case (p.funct3)
        F3_BEQ:           taken = p.eq;
        F3_BNE:           taken = !p.eq;
        F3_BLT, F3_BLTU:  taken = p.lt;
        F3_BGE, F3_BGEU:  taken = !p.lt;
        default:          taken = 1'b0;
      endcase
    end else begin
      case (p.funct3)
        F3_SLT, F3_SLTU:  slt_bit = p.lt;
        default:          slt_bit = 1'b0;
      endcase
    end
    return {taken, slt_bit};
  endfunction

endpackage

// File: rtl/compare.sv
// Unsigned less-than comparator; signed compares reuse it with MSB-flipped operands.
module compare #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_data
);

  assign out_data = a < b;

endmodule

// File: rtl/cmp_branch_unit.sv
// Two-stage branch-resolve / set-less-than unit. S1 registers eq/lt/target,
// S2 registers the decoded result; outputs come straight from S2, gated by valid.
module cmp_branch_unit
  import cmp_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_is_branch,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic            out_taken,
  output logic [XLEN-1:0] out_target
);

  // Handshake: a transfer happens on a rising edge where valid&ready are both 1;
  // the producer holds its payload stable while valid=1 and ready=0.

  logic            s1_valid;
  s1_payload_t     s1_q;
  logic [XLEN-1:0] s1_target;

  logic            s2_valid;
  logic            s2_taken;
  logic            s2_slt;
  logic [XLEN-1:0] s2_target;

  logic            s2_load;
  logic [XLEN-1:0] sign_flip;
  logic [XLEN-1:0] cmp_a;
  logic [XLEN-1:0] cmp_b;
  logic            lt_raw;
  s1_payload_t     s1_d;
  logic [1:0]      s2_d;

  assign s2_load  = !s2_valid || out_ready;
  assign in_ready = !flush && (!s1_valid || s2_load);

  assign sign_flip = is_signed_op(in_is_branch, in_funct3) ? {1'b1, {(XLEN-1){1'b0}}} : '0;
  assign cmp_a     = in_a ^ sign_flip;
  assign cmp_b     = in_b ^ sign_flip;

  compare #(.XLEN(XLEN)) u_compare (
    .a        (cmp_a),
    .b        (cmp_b),
    .out_data (lt_raw)
  );

  always_comb begin
    s1_d           = '0;
    s1_d.is_branch = in_is_branch;
    s1_d.funct3    = in_funct3;
    s1_d.eq        = (in_a == in_b);
    s1_d.lt        = lt_raw;
  end

  assign s2_d = resolve(s1_q);

  // Only the valid bits are reset; payload registers load on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_q      <= s1_d;
        s1_target <= in_pc + in_imm;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
    end else if (flush) begin
      s2_valid <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_taken  <= s2_d[1];
        s2_slt    <= s2_d[0];
        s2_target <= s1_target;
      end
    end
  end

  assign out_valid  = s2_valid;
  assign out_taken  = s2_valid & s2_taken;
  assign out_data   = s2_valid ? {{(XLEN-1){1'b0}}, s2_slt} : '0;
  assign out_target = s2_valid ? s2_target : '0;

endmodule

// File: tb/tb_cmp_branch_unit.sv
// Scoreboard bench for cmp_branch_unit: randomized and directed requests,
// reference model of the RISC-V compare/branch rules, flush and reset cases.
module tb_cmp_branch_unit;

  localparam int XLEN = 32;
  localparam int EW   = 2 * XLEN + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic            in_is_branch;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_a, in_b, in_pc, in_imm;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_data;
  logic            out_taken;
  logic [XLEN-1:0] out_target;

  always #5 clk = ~clk;

  cmp_branch_unit #(.XLEN(XLEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_is_branch (in_is_branch),
    .in_funct3    (in_funct3),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_pc        (in_pc),
    .in_imm       (in_imm),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_taken    (out_taken),
    .out_target   (out_target)
  );

  typedef struct {
    logic            br;
    logic [2:0]      f3;
    logic [XLEN-1:0] a, b, pc, imm;
  } req_t;

  logic [EW-1:0] exp_q[$];
  int            acc_q[$];
  bit            lat_q[$];
  req_t          req_q[$];

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   tag_lat = 0;
  bit   done_flag = 0;
  bit   acc_prev = 0;
  bit   prev_flush = 0;
  bit   hold_v = 0;
  logic [EW-1:0] held;

  // Reference model: results straight from the ISA definitions.
  function automatic logic [EW-1:0] model(input req_t r);
    logic signed [XLEN-1:0] sa, sb;
    logic [XLEN-1:0] d;
    logic t;
    sa = r.a;
    sb = r.b;
    d  = '0;
    t  = 1'b0;
    if (r.br) begin
      case (r.f3)
        3'd0: t = (r.a == r.b);
        3'd1: t = (r.a != r.b);
        3'd4: t = (sa < sb);
        3'd5: t = (sa >= sb);
        3'd6: t = (r.a < r.b);
        3'd7: t = (r.a >= r.b);
        default: t = 1'b0;
      endcase
    end else begin
      if (r.f3 == 3'd2) d = (sa < sb) ? 1 : 0;
      else if (r.f3 == 3'd3) d = (r.a < r.b) ? 1 : 0;
    end
    return {d, t, r.pc + r.imm};
  endfunction

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    req_t cur;
    logic [EW-1:0] act;
    logic [EW-1:0] exp_v;
    int acc;
    bit lat;
    cyc++;
    act = {out_data, out_taken, out_target};
    if (rst) begin
      check("reset_out_valid", EW'(out_valid), '0);
      check("reset_outputs", act, '0);
      exp_q.delete();
      acc_q.delete();
      lat_q.delete();
      hold_v = 0;
      prev_flush = 0;
    end else begin
      if (prev_flush) check("flush_out_valid", EW'(out_valid), '0);
      check("in_ready", EW'(in_ready), EW'(!flush && !(exp_q.size() >= 2 && !out_ready)));
      if (exp_q.size() == 0) check("idle_out_valid", EW'(out_valid), '0);
      if (out_valid && !out_ready && !flush) begin
        if (hold_v) check("stall_hold", act, held);
        held = act;
        hold_v = 1;
      end else begin
        hold_v = 0;
      end
      if (flush) begin
        exp_q.delete();
        acc_q.delete();
        lat_q.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_output", act, '0);
          end else begin
            exp_v = exp_q.pop_front();
            acc = acc_q.pop_front();
            lat = lat_q.pop_front();
            check("result", act, exp_v);
            if (lat) check("latency", EW'(cyc - acc), EW'(2));
          end
        end
        if (in_valid && in_ready) begin
          cur.br = in_is_branch; cur.f3 = in_funct3;
          cur.a = in_a; cur.b = in_b; cur.pc = in_pc; cur.imm = in_imm;
          exp_q.push_back(model(cur));
          acc_q.push_back(cyc);
          lat_q.push_back(tag_lat);
        end
      end
      prev_flush = flush;
      if (done_flag) check("drained", EW'(exp_q.size()), '0);
    end
  end

  task automatic drive(input req_t r);
    in_is_branch = r.br; in_funct3 = r.f3;
    in_a = r.a; in_b = r.b; in_pc = r.pc; in_imm = r.imm;
  endtask

  function automatic req_t mk(input logic br, input logic [2:0] f3,
                              input logic [XLEN-1:0] a, b, pc, imm);
    req_t r;
    r.br = br; r.f3 = f3; r.a = a; r.b = b; r.pc = pc; r.imm = imm;
    return r;
  endfunction

  function automatic req_t rand_req();
    logic [XLEN-1:0] edge_v[5];
    req_t r;
    edge_v = '{32'h0, 32'h1, 32'h7fff_ffff, 32'h8000_0000, 32'hffff_ffff};
    r.br = 1'($urandom_range(0, 1));
    r.f3 = 3'($urandom_range(0, 7));
    case ($urandom_range(0, 2))
      0: begin r.a = $urandom; r.b = $urandom; end
      1: begin r.a = $urandom; r.b = r.a; end
      default: begin r.a = edge_v[$urandom_range(0, 4)]; r.b = edge_v[$urandom_range(0, 4)]; end
    endcase
    r.pc  = $urandom;
    r.imm = $urandom;
    return r;
  endfunction

  // One cycle of the valid/ready driver, with out_ready for that cycle.
  task automatic step(input logic ordy);
    @(posedge clk); #1;
    if (acc_prev) in_valid = 1'b0;
    out_ready = ordy;
    if (!in_valid && req_q.size() > 0) begin
      drive(req_q.pop_front());
      in_valid = 1'b1;
    end
    @(negedge clk);
    acc_prev = in_valid && in_ready;
  endtask

  // Single request into an empty pipeline with latency tagged for checking.
  task automatic direct(input req_t r);
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive(r);
    tag_lat = 1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    tag_lat = 0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    direct(mk(1, 3'd4, 32'hffff_ffff, 32'h1, 32'h100, 32'h8));
    direct(mk(1, 3'd6, 32'hffff_ffff, 32'h1, 32'h100, 32'h8));
    direct(mk(0, 3'd3, 32'h3, 32'h3, 32'h0, 32'h0));
    direct(mk(0, 3'd2, 32'h8000_0000, 32'h0, 32'h4, 32'h4));
    direct(mk(1, 3'd0, 32'h5, 32'h5, 32'hffff_fff0, 32'h20));
    direct(mk(1, 3'd5, 32'h8000_0000, 32'h8000_0000, 32'h40, 32'hffff_fffc));
    direct(mk(1, 3'd2, 32'h0, 32'h1, 32'h10, 32'h10));
    direct(mk(0, 3'd0, 32'h0, 32'h1, 32'h10, 32'h10));

    // Five back-to-back with a three-cycle output stall
    for (int i = 0; i < 5; i++) req_q.push_back(rand_req());
    for (int k = 0; k < 15; k++) step(!(k >= 3 && k <= 5));

    // Flush with both stages full; the same-cycle input must be dropped
    for (int i = 0; i < 2; i++) req_q.push_back(rand_req());
    repeat (4) step(1'b0);
    @(posedge clk); #1;
    drive(rand_req());
    in_valid = 1'b1; out_ready = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; acc_prev = 0;
    req_q.push_back(rand_req());
    repeat (5) step(1'b1);

    // Asynchronous reset between edges with both stages full
    for (int i = 0; i < 2; i++) req_q.push_back(rand_req());
    repeat (4) step(1'b0);
    @(posedge clk); #2;
    rst = 1'b1; in_valid = 1'b0; acc_prev = 0;
    #5 rst = 1'b0;
    req_q.push_back(rand_req());
    repeat (6) step(1'b1);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0 && req_q.size() < 2) req_q.push_back(rand_req());
      step($urandom_range(0, 3) != 0);
    end
    repeat (10) step(1'b1);

    done_flag = 1;
    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
